// File: rtl/aes_pkg.sv
// Shared AES constants, round-index type and the key-schedule round constant table.
package aes_pkg;

  localparam int unsigned AES_NR     = 10;
  localparam int unsigned AES_WORD_W = 32;
  localparam int unsigned AES_KEY_W  = 128;

  typedef logic [3:0] aes_round_t;

  // Rcon(r) is the constant that links round key r-1 to round key r.
  function automatic logic [7:0] aes_rcon(input aes_round_t r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_inv_ks_step.sv
// One reverse AES-128 key-schedule step: round key r plus SubWord(RotWord(p3)) gives key r-1.
module aes_inv_ks_step
  import aes_pkg::*;
(
  input  logic [AES_KEY_W-1:0]  key,
  input  logic [AES_WORD_W-1:0] sub_word,
  input  logic [7:0]            rcon,
  output logic [AES_KEY_W-1:0]  key_prev
);

  logic [AES_WORD_W-1:0] w0, w1, w2, w3;

  always_comb begin
    w0       = key[127:96];
    w1       = key[95:64];
    w2       = key[63:32];
    w3       = key[31:0];
    key_prev = {w0 ^ sub_word ^ {rcon, 24'h0}, w1 ^ w0, w2 ^ w1, w3 ^ w2};
  end

endmodule

// File: rtl/aes_sbox.sv
// AES byte substitution: forward S-box when enc=1, inverse S-box when enc=0.
module aes_sbox (
  input  logic       enc,
  input  logic [7:0] din,
  output logic [7:0] dout
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = '0;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] x);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] x);
    return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
  endfunction

  always_comb begin
    dout = enc ? affine(gf_inv(din)) : gf_inv(inv_affine(din));
  end

endmodule

// File: rtl/aes_inv_key_sched.sv
// Iterative reverse AES-128 key schedule emitting round keys NR..0 over valid/ready.
// Optional macro AES_INV_KS_ZEROIZE_EN wipes key state after the last key and on abort.
module aes_inv_key_sched
  import aes_pkg::*;
#(
  parameter int unsigned NUM_SBOX = 1,
  parameter int unsigned NR       = AES_NR
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [AES_KEY_W-1:0] key_in,
  output logic [AES_KEY_W-1:0] rk_out,
  output logic [3:0]           rk_round,
  output logic                 rk_valid,
  input  logic                 rk_ready,
  output logic                 busy
);

  localparam int unsigned SUB_CYC  = 4 / NUM_SBOX;
  localparam logic [1:0]  CNT_LAST = 2'(SUB_CYC - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EMIT = 2'd1;
  localparam logic [1:0] SUB  = 2'd2;

  logic [1:0]                state_q;
  logic [1:0]                cnt_q;
  aes_round_t                round_q;
  logic [AES_KEY_W-1:0]      key_q;
  logic [AES_KEY_W-1:0]      key_prev;
  logic [3:0][7:0]           sub_q;
  logic [3:0][7:0]           rot;
  logic [3:0][7:0]           sub_byte;
  logic [AES_WORD_W-1:0]     p3;
  logic [AES_WORD_W-1:0]     sub_word;
  logic [7:0]                rcon;
  logic [NUM_SBOX-1:0][1:0]  slot;
  logic [NUM_SBOX-1:0][7:0]  sbox_in;
  logic [NUM_SBOX-1:0][7:0]  sbox_out;

  // Byte 0 is the MSB of RotWord(p3); each SUB cycle handles NUM_SBOX consecutive bytes.
  always_comb begin
    p3     = key_q[31:0] ^ key_q[63:32];
    rot[0] = p3[23:16];
    rot[1] = p3[15:8];
    rot[2] = p3[7:0];
    rot[3] = p3[31:24];
    sub_byte = sub_q;
    for (int i = 0; i < int'(NUM_SBOX); i++) begin
      slot[i]           = 2'(int'(cnt_q) * int'(NUM_SBOX) + i);
      sbox_in[i]        = rot[slot[i]];
      sub_byte[slot[i]] = sbox_out[i];
    end
    sub_word = {sub_byte[0], sub_byte[1], sub_byte[2], sub_byte[3]};
    rcon     = aes_rcon(round_q);
  end

  for (genvar g = 0; g < int'(NUM_SBOX); g++) begin : g_sbox
    aes_sbox u_sbox (
      .enc  (1'b1),
      .din  (sbox_in[g]),
      .dout (sbox_out[g])
    );
  end

  aes_inv_ks_step u_step (
    .key      (key_q),
    .sub_word (sub_word),
    .rcon     (rcon),
    .key_prev (key_prev)
  );

`ifdef AES_INV_KS_ZEROIZE_EN
  logic wipe;
  assign wipe = abort | ((state_q == EMIT) & rk_ready & (round_q == '0));
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      round_q <= '0;
      key_q   <= '0;
      sub_q   <= '0;
    end else begin
      if (abort) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              key_q   <= key_in;
              round_q <= 4'(NR);
              state_q <= EMIT;
            end
          end
          EMIT: begin
            if (rk_ready) begin
              cnt_q   <= '0;
              state_q <= (round_q == '0) ? IDLE : SUB;
            end
          end
          SUB: begin
            for (int i = 0; i < int'(NUM_SBOX); i++) begin
              sub_q[slot[i]] <= sbox_out[i];
            end
            if (cnt_q == CNT_LAST) begin
              key_q   <= key_prev;
              round_q <= round_q - 4'd1;
              cnt_q   <= '0;
              state_q <= EMIT;
            end else begin
              cnt_q <= cnt_q + 2'd1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
`ifdef AES_INV_KS_ZEROIZE_EN
      if (wipe) begin
        key_q <= '0;
        sub_q <= '0;
      end
`endif
    end
  end

  assign rk_valid = (state_q == EMIT);
  assign busy     = (state_q != IDLE);
  assign rk_round = round_q;

`ifdef AES_INV_KS_ZEROIZE_EN
  assign rk_out = rk_valid ? key_q : '0;
`else
  assign rk_out = key_q;
`endif

endmodule
